// File: rtl/fig_pkg.sv
// -----------------------------------------------------------------------------
// fig_pkg
// Constants shared by the figure-overlay generator:
//   - overlay FSM state encoding (legacy 2-bit constants)
//   - legal figure ROM read-latency range
//   - default figure geometry (64 x 64 pixels)
// -----------------------------------------------------------------------------
package fig_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SHOW    = 2'd2;

    localparam int unsigned ROM_LAT_MIN = 1;
    localparam int unsigned ROM_LAT_MAX = 3;

    localparam int unsigned FIG_W_LOG2_DEF = 6;
    localparam int unsigned FIG_H_DEF      = 64;

    // Forces the ROM latency into the supported range so the alignment
    // pipeline depth is always valid.
    function automatic int unsigned clamp_rom_latency(input int unsigned lat);
        if (lat < ROM_LAT_MIN) return ROM_LAT_MIN;
        if (lat > ROM_LAT_MAX) return ROM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/fig_delay_line.sv
// -----------------------------------------------------------------------------
// fig_delay_line
// Fixed-depth shift register used to align video timing/pixel data with the
// figure ROM read data.
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset, clears every stage
//   din   : WIDTH-bit input word
//   dout  : din delayed by DEPTH clock cycles
// -----------------------------------------------------------------------------
module fig_delay_line
    import fig_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fig_overlay_gen.sv
// -----------------------------------------------------------------------------
// fig_overlay_gen
// Overlays a figure (read from an external figure ROM) onto a camera video
// stream at a programmable position. Figure changes only take effect at the
// start of a frame; a clear removes the overlay immediately.
//   clk, rst_n                  : pixel clock, async active-low reset
//   vid_vs/hs/de, vid_data      : input video timing and camera pixel
//   fig_valid, fig_sel          : request to show figure fig_sel
//   fig_clear                   : remove the overlay (wins over fig_valid)
//   pos_x, pos_y                : overlay top-left pixel coordinate
//   rom_addr, rom_rd_data       : figure ROM address / read data
//   out_vs/hs/de, out_data      : video delayed by ROM_LATENCY+2 cycles
// -----------------------------------------------------------------------------
module fig_overlay_gen
    import fig_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH           = 15,
    parameter int unsigned DATA_WIDTH           = 16,
    parameter int unsigned FIG_W_LOG2           = FIG_W_LOG2_DEF,
    parameter int unsigned FIG_H                = FIG_H_DEF,
    parameter int unsigned ROM_LATENCY          = 1,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vid_vs,
    input  logic                  vid_hs,
    input  logic                  vid_de,
    input  logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  fig_valid,
    input  logic [2:0]            fig_sel,
    input  logic                  fig_clear,
    input  logic [11:0]           pos_x,
    input  logic [11:0]           pos_y,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  out_vs,
    output logic                  out_hs,
    output logic                  out_de,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned LAT      = clamp_rom_latency(ROM_LATENCY);
    localparam int unsigned FIG_W    = 1 << FIG_W_LOG2;
    localparam int unsigned FIG_SIZE = FIG_W * FIG_H;
    localparam int unsigned DLY_W    = DATA_WIDTH + 4;

    // ---------------- pixel coordinate counters ----------------
    logic [11:0] x, y;
    logic        vs_q, de_q;
    logic        vs_rise, de_fall;

    assign vs_rise = vid_vs && !vs_q;
    assign de_fall = !vid_de && de_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else begin
            vs_q <= vid_vs;
            de_q <= vid_de;
            if (vid_de)       x <= x + 12'd1;
            else if (de_fall) x <= '0;
            if (vs_rise)      y <= '0;
            else if (de_fall) y <= y + 12'd1;
        end
    end

    // ---------------- window detection and ROM address ----------------
    logic [12:0]           x_end, y_end;
    logic                  in_win;
    logic [11:0]           dx, dy;
    logic [2:0]            fig_idx;
    logic [ADDR_WIDTH-1:0] addr_next;

    // 13-bit window ends so a window running past 4095 cannot wrap.
    assign x_end  = {1'b0, pos_x} + 13'(FIG_W);
    assign y_end  = {1'b0, pos_y} + 13'(FIG_H);
    assign in_win = vid_de && (x >= pos_x) && ({1'b0, x} < x_end)
                           && (y >= pos_y) && ({1'b0, y} < y_end);

    assign dx        = x - pos_x;
    assign dy        = y - pos_y;
    assign addr_next = ADDR_WIDTH'(32'(fig_idx) * FIG_SIZE)
                     + ADDR_WIDTH'(32'(dy) << FIG_W_LOG2)
                     + ADDR_WIDTH'(dx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rom_addr <= '0;
        else if (in_win) rom_addr <= addr_next;
    end

    // ---------------- overlay control FSM ----------------
    logic [1:0] state;
    logic [2:0] pend_sel;
    logic       fig_live;
    logic       ov_en;

    // fig_live remembers that a figure was committed, so a new request made
    // mid-frame (SHOW -> PENDING) keeps the current figure visible until the
    // next frame start instead of blanking it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pend_sel <= '0;
            fig_idx  <= '0;
            fig_live <= 1'b0;
        end else if (fig_clear) begin
            state    <= ST_IDLE;
            fig_live <= 1'b0;
        end else if (fig_valid) begin
            state    <= ST_PENDING;
            pend_sel <= fig_sel;
        end else if (state == ST_PENDING && vs_rise) begin
            state    <= ST_SHOW;
            fig_idx  <= pend_sel;
            fig_live <= 1'b1;
        end
    end

    assign ov_en = (state == ST_SHOW) || (state == ST_PENDING && fig_live);

    // ---------------- alignment pipeline and output mux ----------------
    logic                  d_vs, d_hs, d_de, d_win;
    logic [DATA_WIDTH-1:0] d_data;

    fig_delay_line #(
        .WIDTH (DLY_W),
        .DEPTH (LAT + 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({vid_vs, vid_hs, vid_de, in_win, vid_data}),
        .dout  ({d_vs, d_hs, d_de, d_win, d_data})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vs   <= 1'b0;
            out_hs   <= 1'b0;
            out_de   <= 1'b0;
            out_data <= '0;
        end else begin
            out_vs   <= d_vs;
            out_hs   <= d_hs;
            out_de   <= d_de;
            out_data <= (d_win && ov_en && rom_rd_data != KEY_COLOR) ? rom_rd_data : d_data;
        end
    end

endmodule

// File: tb/tb_fig_overlay_gen.sv
// -----------------------------------------------------------------------------
// tb_fig_overlay_gen
// Directed + randomized bench for fig_overlay_gen. The figure ROM model
// returns its own address, so a figure pixel's expected colour is simply its
// ROM address; address 0 therefore holds the key colour.
// -----------------------------------------------------------------------------
module tb_fig_overlay_gen;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_vs, vid_hs, vid_de;
    logic [15:0] vid_data;
    logic        fig_valid, fig_clear;
    logic [2:0]  fig_sel;
    logic [11:0] pos_x, pos_y;
    logic [14:0] rom_addr;
    logic [15:0] rom_rd_data = 16'h0;
    logic        out_vs, out_hs, out_de;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    // Figure ROM: one-cycle registered read, contents = address.
    always @(posedge clk) rom_rd_data <= {1'b0, rom_addr};

    fig_overlay_gen #(
        .ADDR_WIDTH  (15),
        .DATA_WIDTH  (16),
        .FIG_W_LOG2  (6),
        .FIG_H       (64),
        .ROM_LATENCY (LAT),
        .KEY_COLOR   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vid_vs      (vid_vs),
        .vid_hs      (vid_hs),
        .vid_de      (vid_de),
        .vid_data    (vid_data),
        .fig_valid   (fig_valid),
        .fig_sel     (fig_sel),
        .fig_clear   (fig_clear),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .out_vs      (out_vs),
        .out_hs      (out_hs),
        .out_de      (out_de),
        .out_data    (out_data)
    );

    typedef struct {
        logic        vs, hs, de;
        logic [15:0] data;
        int          x, y;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: frame-level overlay state.
    bit   live, has_pend;
    int   cur_idx, pend_idx;
    int   pos_xi, pos_yi;
    logic prev_vs;

    bit          capturing = 1'b0;
    logic [15:0] cap [int];
    logic [15:0] cam [int];

    function automatic int key(input int px, input int py);
        return py * 4096 + px;
    endfunction

    function automatic logic [15:0] model_pix(input logic de, input int px, input int py,
                                              input logic [15:0] cam_px);
        int addr;
        if (de && live && px >= pos_xi && px < pos_xi + 64 && py >= pos_yi && py < pos_yi + 64) begin
            addr = (cur_idx * 4096 + (py - pos_yi) * 64 + (px - pos_xi)) % 32768;
            if (addr != 0) return 16'(addr);
        end
        return cam_px;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_zero();
        exp_t z;
        z.vs = 1'b0; z.hs = 1'b0; z.de = 1'b0; z.data = 16'h0; z.x = -1; z.y = -1;
        exp_q.push_back(z);
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input logic [15:0] d,
                        input int px, input int py,
                        input logic fv, input logic [2:0] fs, input logic fc);
        exp_t e, ne;
        @(negedge clk);
        e = exp_q.pop_front();
        check("timing", {29'd0, out_vs, out_hs, out_de}, {29'd0, e.vs, e.hs, e.de});
        check("data", {16'd0, out_data}, {16'd0, e.data});
        if (capturing && e.de) cap[key(e.x, e.y)] = out_data;
        vid_vs = vs; vid_hs = hs; vid_de = de; vid_data = d;
        fig_valid = fv; fig_sel = fs; fig_clear = fc;
        ne.vs = vs; ne.hs = hs; ne.de = de; ne.x = px; ne.y = py;
        ne.data = model_pix(de, px, py, d);
        if (capturing && de) cam[key(px, py)] = d;
        exp_q.push_back(ne);
        if (fc) begin
            live = 1'b0; has_pend = 1'b0;
        end else if (fv) begin
            pend_idx = int'(fs); has_pend = 1'b1;
        end
        if (vs && !prev_vs && has_pend) begin
            live = 1'b1; cur_idx = pend_idx; has_pend = 1'b0;
        end
        prev_vs = vs;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 16'($urandom), -1, -1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic cmd(input logic fv, input logic [2:0] fs, input logic fc);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 16'($urandom), -1, -1, fv, fs, fc);
        idle(2);
    endtask

    task automatic set_pos(input int px, input int py);
        pos_xi = px; pos_yi = py;
        pos_x = 12'(px); pos_y = 12'(py);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vid_vs = 0; vid_hs = 0; vid_de = 0; vid_data = 0;
        fig_valid = 0; fig_sel = 0; fig_clear = 0;
        #1;
        check("reset_out", {13'd0, out_vs, out_hs, out_de, out_data}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", {13'd0, out_vs, out_hs, out_de, out_data}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) push_zero();
        live = 1'b0; has_pend = 1'b0; prev_vs = 1'b0;
    endtask

    // One frame: vsync, vblank, then `lines` active lines of `width` pixels.
    // An optional command is issued in the hblank of line ev_line, and an
    // optional reset at the start of line rst_line.
    task automatic frame(input int lines, input int width, input int ev_line,
                         input logic ev_fv, input logic [2:0] ev_fs, input logic ev_fc,
                         input int rst_line);
        repeat (2) step(1'b1, 1'b0, 1'b0, 16'($urandom), -1, -1, 1'b0, 3'd0, 1'b0);
        idle(3);
        for (int ln = 0; ln < lines; ln++) begin
            if (ln == rst_line) do_reset();
            for (int px = 0; px < width; px++)
                step(1'b0, 1'b0, 1'b1, 16'($urandom), px, ln, 1'b0, 3'd0, 1'b0);
            for (int h = 0; h < 6; h++) begin
                if (h == 3 && ln == ev_line)
                    step(1'b0, 1'b0, 1'b0, 16'($urandom), -1, -1, ev_fv, ev_fs, ev_fc);
                else
                    step(1'b0, (h == 1 || h == 2), 1'b0, 16'($urandom), -1, -1, 1'b0, 3'd0, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        vid_vs = 0; vid_hs = 0; vid_de = 0; vid_data = 0;
        fig_valid = 0; fig_sel = 0; fig_clear = 0;
        live = 0; has_pend = 0; cur_idx = 0; pend_idx = 0; prev_vs = 0;
        set_pos(100, 50);
        #2;
        do_reset();

        // Latency: a single active pixel in cycle 10 after reset.
        idle(9);
        step(1'b0, 1'b0, 1'b1, 16'hABCD, 0, 0, 1'b0, 3'd0, 1'b0);
        idle(6);

        // Overlay of figure 2 at (100,50).
        cmd(1'b1, 3'd2, 1'b0);
        capturing = 1'b1; cap.delete(); cam.delete();
        frame(116, 170, -1, 1'b0, 3'd0, 1'b0, -1);
        check("ovl_100_50",   {16'd0, cap[key(100, 50)]},  32'h2000);
        check("ovl_163_113",  {16'd0, cap[key(163, 113)]}, 32'h2FFF);
        check("pass_164_50",  {16'd0, cap[key(164, 50)]},  {16'd0, cam[key(164, 50)]});

        // Frame sync: request figure 3 mid-frame while figure 1 is shown.
        set_pos(10, 5);
        cmd(1'b1, 3'd1, 1'b0);
        cap.delete(); cam.delete();
        frame(20, 90, 8, 1'b1, 3'd3, 1'b0, -1);
        check("sync_before", {16'd0, cap[key(10, 5)]},  32'h1000);
        check("sync_after",  {16'd0, cap[key(10, 15)]}, 32'h1280);
        cap.delete(); cam.delete();
        frame(20, 90, -1, 1'b0, 3'd0, 1'b0, -1);
        check("sync_next", {16'd0, cap[key(10, 15)]}, 32'h3280);

        // Key colour with figure 0: word 0 is transparent, word 1 is drawn.
        cmd(1'b1, 3'd0, 1'b0);
        cap.delete(); cam.delete();
        frame(8, 90, -1, 1'b0, 3'd0, 1'b0, -1);
        check("key_pass", {16'd0, cap[key(10, 5)]}, {16'd0, cam[key(10, 5)]});
        check("key_one",  {16'd0, cap[key(11, 5)]}, 32'h0001);

        // Clear together with a valid request mid-frame.
        cap.delete(); cam.delete();
        frame(20, 90, 8, 1'b1, 3'd5, 1'b1, -1);
        check("clr_before", {16'd0, cap[key(11, 5)]},  32'h0001);
        check("clr_after",  {16'd0, cap[key(11, 15)]}, {16'd0, cam[key(11, 15)]});
        cap.delete(); cam.delete();
        frame(8, 90, -1, 1'b0, 3'd0, 1'b0, -1);
        check("clr_idle", {16'd0, cap[key(11, 5)]}, {16'd0, cam[key(11, 5)]});

        // Clipping at the right edge of a 1280-pixel line.
        set_pos(1260, 0);
        cmd(1'b1, 3'd2, 1'b0);
        cap.delete(); cam.delete();
        frame(3, 1280, -1, 1'b0, 3'd0, 1'b0, -1);
        check("clip_1260_0", {16'd0, cap[key(1260, 0)]}, 32'h2000);
        check("clip_1279_0", {16'd0, cap[key(1279, 0)]}, 32'h2013);
        check("clip_1260_1", {16'd0, cap[key(1260, 1)]}, 32'h2040);
        check("clip_0_1",    {16'd0, cap[key(0, 1)]},    {16'd0, cam[key(0, 1)]});
        check("clip_43_1",   {16'd0, cap[key(43, 1)]},   {16'd0, cam[key(43, 1)]});

        // Mid-frame reset, then recovery only after fig_valid plus a new frame.
        set_pos(10, 5);
        cmd(1'b1, 3'd6, 1'b0);
        cap.delete(); cam.delete();
        frame(20, 90, -1, 1'b0, 3'd0, 1'b0, 10);
        check("rst_before", {16'd0, cap[key(11, 5)]},  32'h6001);
        check("rst_after",  {16'd0, cap[key(11, 12)]}, {16'd0, cam[key(11, 12)]});
        cap.delete(); cam.delete();
        frame(8, 90, -1, 1'b0, 3'd0, 1'b0, -1);
        check("rst_idle", {16'd0, cap[key(11, 5)]}, {16'd0, cam[key(11, 5)]});
        cmd(1'b1, 3'd4, 1'b0);
        cap.delete(); cam.delete();
        frame(8, 90, -1, 1'b0, 3'd0, 1'b0, -1);
        check("rst_recover", {16'd0, cap[key(11, 5)]}, 32'h4001);
        capturing = 1'b0;

        // Randomized positions, figures and commands.
        for (int f = 0; f < 6; f++) begin
            int r;
            set_pos(int'($urandom_range(0, 80)), int'($urandom_range(0, 15)));
            r = int'($urandom_range(0, 3));
            if (r != 0) cmd(r[0], 3'($urandom), r[1]);
            frame(16, 100, int'($urandom_range(0, 20)), 1'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) == 0), -1);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
